// File: rtl/nv_lsd_norm_seq.sv
// rtl/nv_lsd_norm_seq.sv - two-requester sign-bit normalizer (IDLE/DET/NORM/OUT)
// Optional round-robin arbitration: define NV_LSD_NORM_RR_EN.
module nv_lsd_norm_seq #(
    parameter int DATA_WIDTH = 16,
    localparam int ENC_WIDTH = (DATA_WIDTH <= 2)  ? 1 :
                               (DATA_WIDTH <= 4)  ? 2 :
                               (DATA_WIDTH <= 8)  ? 3 :
                               (DATA_WIDTH <= 16) ? 4 :
                               (DATA_WIDTH <= 32) ? 5 :
                               (DATA_WIDTH <= 64) ? 6 : 7
) (
    input  logic                  nvdla_core_clk,
    input  logic                  nvdla_core_rstn,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ENC_WIDTH-1:0]  out_enc,
    output logic                  out_id,
    output logic                  busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DET  = 2'd1;
    localparam logic [1:0] NORM = 2'd2;
    localparam logic [1:0] OUT  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] opnd_q;
    logic [ENC_WIDTH-1:0]  enc_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [ENC_WIDTH-1:0]  out_enc_q;
    logic                  id_q;
    logic                  idle;
    logic                  gnt1;
    logic                  hs;
    logic [ENC_WIDTH-1:0]  cnt;
    logic                  run;

`ifdef NV_LSD_NORM_RR_EN
    logic rr_ptr_q;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            rr_ptr_q <= 1'b0;
        end else if (hs) begin
            rr_ptr_q <= ~gnt1;
        end
    end

    always_comb begin
        gnt1 = 1'b0;
        if (req0_valid && req1_valid) gnt1 = rr_ptr_q;
        else                          gnt1 = req1_valid;
    end
`else
    always_comb begin
        gnt1 = 1'b0;
        gnt1 = req1_valid && !req0_valid;
    end
`endif

    assign idle       = (state_q == IDLE);
    assign hs         = idle && (req0_valid || req1_valid);
    assign req0_ready = idle && req0_valid && !gnt1;
    assign req1_ready = idle && gnt1;
    assign busy       = !idle;
    assign out_valid  = (state_q == OUT);
    assign out_data   = out_data_q;
    assign out_enc    = out_enc_q;
    assign out_id     = id_q;

    // Count the run of bits matching the MSB, starting just below it; stops at first differing bit.
    always_comb begin
        cnt = '0;
        run = 1'b1;
        for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
            if (run && (opnd_q[i] == opnd_q[DATA_WIDTH-1])) cnt = cnt + ENC_WIDTH'(1);
            else                                            run = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hs) state_d = DET;
            DET:     state_d = NORM;
            NORM:    state_d = OUT;
            default: if (out_ready) state_d = IDLE;
        endcase
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q    <= IDLE;
            opnd_q     <= '0;
            enc_q      <= '0;
            out_data_q <= '0;
            out_enc_q  <= '0;
            id_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                opnd_q <= gnt1 ? req1_data : req0_data;
                id_q   <= gnt1;
            end
            if (state_q == DET) enc_q <= cnt;
            if (state_q == NORM) begin
                out_data_q <= opnd_q << enc_q;
                out_enc_q  <= enc_q;
            end
        end
    end

endmodule
